// File: rtl/arbiter_requester_pkg.sv
// Shared types and helpers for the arbiter requester front end.
package arb_pkg;

  localparam int unsigned ARB_N = 2;

  typedef enum logic {
    IDLE,
    TENURE
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic onehot_check(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/arbiter_requester_if.sv
// Client/arbiter signal bundle for arbiter_requester; master = clients+arbiter, slave = requester.
interface arbiter_requester_if
  import arb_pkg::*;
#(
  parameter int unsigned N = ARB_N
) ();

  logic [N-1:0] push;
  logic [N-1:0] busy;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] ack;
  logic [N-1:0] owner;
  logic         active;
  logic         err;
  logic         err_clr;

  modport master (
    output push, grant, err_clr,
    input  busy, req, ack, owner, active, err
  );

  modport slave (
    input  push, grant, err_clr,
    output busy, req, ack, owner, active, err
  );

endinterface

// File: rtl/arbiter_requester_hold_counter.sv
// Tenure down counter: loads a start value and counts down, holding at zero.
module hold_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          CLK,
  input  logic          ASYNCRESETN,
  input  logic          i_load,
  input  logic          i_dec,
  input  logic [CW-1:0] i_val,
  output logic [CW-1:0] o_value,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/arbiter_requester.sv
// Requester front end: latches client pushes, drives the arbiter req vector,
// acks the granted client, holds a fixed tenure and flags grant protocol errors.
module arbiter_requester
  import arb_pkg::*;
#(
  parameter int unsigned N    = ARB_N,
  parameter int unsigned HOLD = 3,
  parameter int unsigned CW   = 8
) (
  input  logic                CLK,
  input  logic                ASYNCRESETN,
  arbiter_requester_if.slave  bus
);

  localparam logic [CW-1:0] LOAD = CW'(HOLD - 1);

  state_t        r_state;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  r_ack;
  logic [N-1:0]  r_owner;
  logic          r_err;

  logic [N-1:0]  w_req;
  logic [N-1:0]  w_take;
  logic          w_valid;
  logic          w_err_set;
  logic          w_dec;
  logic          w_zero;
  logic [CW-1:0] w_cnt;

  // Any nonzero grant that is not a valid IDLE grant (including all TENURE grants) is an error.
  always_comb begin
    w_req     = (r_state == IDLE) ? r_pending : '0;
    w_valid   = (r_state == IDLE) && onehot_check(32'(bus.grant))
                && ((bus.grant & ~w_req) == '0);
    w_take    = w_valid ? bus.grant : '0;
    w_err_set = (bus.grant != '0) && !w_valid;
    w_dec     = (r_state == TENURE);
  end

  hold_counter #(.CW(CW)) u_hold (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .i_load      (w_valid),
    .i_dec       (w_dec),
    .i_val       (LOAD),
    .o_value     (w_cnt),
    .o_zero      (w_zero)
  );

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_ack     <= '0;
      r_owner   <= '0;
      r_err     <= 1'b0;
    end else begin
      // A push colliding with its own grant re-arms the pending bit.
      r_pending <= (r_pending & ~w_take) | bus.push;
      r_ack     <= w_take;
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= TENURE;
            r_owner <= bus.grant;
          end
        end
        TENURE: begin
          if (w_zero) begin
            r_state <= IDLE;
            r_owner <= '0;
          end
        end
      endcase
    end
  end

  assign bus.req    = w_req;
  assign bus.busy   = r_pending;
  assign bus.ack    = r_ack;
  assign bus.owner  = r_owner;
  assign bus.active = (r_state == TENURE);
  assign bus.err    = r_err;

  a_cnt_range: assert property (@(posedge CLK) disable iff (!ASYNCRESETN) w_cnt <= LOAD);

endmodule

// File: tb/tb_arbiter_requester.sv
// Bench for arbiter_requester with N=2, HOLD=3 behind a lowest-index comb arbiter.
module tb_arbiter_requester;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;

  logic       CLK;
  logic       rst_n;
  logic       force_en;
  logic [1:0] force_val;
  int         cyc;
  int         n_checks;
  int         n_errors;
  exp_t       q[$];

  arbiter_requester_if #(.N(2)) bus ();

  arbiter_requester #(.N(2), .HOLD(3), .CW(8)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (rst_n),
    .bus         (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc++;

  // Lowest-index arbiter, optionally overridden to inject illegal grants.
  always_comb begin
    bus.grant = force_en ? force_val : (bus.req & ~(bus.req - 2'd1));
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every observed ack must match the next expected value and cycle.
  always @(negedge CLK) begin
    if (rst_n && (bus.ack != '0)) begin
      if (q.size() == 0) begin
        check_val("ack_unexpected", 32'(bus.ack), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_val("ack_val", 32'(bus.ack), 32'(e.val));
        check_val("ack_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic t_single(input string p);
    bus.push = 2'b01;
    q.push_back('{cyc + 2, 2'b01});
    step();
    bus.push = '0;
    check_val({p, "_req_c1"},   32'(bus.req),   32'h1);
    check_val({p, "_grant_c1"}, 32'(bus.grant), 32'h1);
    check_val({p, "_busy_c1"},  32'(bus.busy),  32'h1);
    step();
    check_val({p, "_act_c2"},   32'(bus.active), 32'h1);
    check_val({p, "_req_c2"},   32'(bus.req),    32'h0);
    check_val({p, "_own_c2"},   32'(bus.owner),  32'h1);
    check_val({p, "_busy_c2"},  32'(bus.busy),   32'h0);
    step();
    check_val({p, "_act_c3"},   32'(bus.active), 32'h1);
    step();
    check_val({p, "_act_c4"},   32'(bus.active), 32'h1);
    check_val({p, "_req_c4"},   32'(bus.req),    32'h0);
    step();
    check_val({p, "_act_c5"},   32'(bus.active), 32'h0);
    check_val({p, "_own_c5"},   32'(bus.owner),  32'h0);
  endtask

  task automatic check_all_zero(input string p);
    check_val({p, "_busy"},   32'(bus.busy),   32'h0);
    check_val({p, "_req"},    32'(bus.req),    32'h0);
    check_val({p, "_owner"},  32'(bus.owner),  32'h0);
    check_val({p, "_active"}, 32'(bus.active), 32'h0);
    check_val({p, "_err"},    32'(bus.err),    32'h0);
    check_val({p, "_ack"},    32'(bus.ack),    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout (cyc %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    force_en  = 1'b0;
    force_val = '0;
    bus.push    = '0;
    bus.err_clr = 1'b0;
    #2;
    check_all_zero("rst");
    #20 rst_n = 1'b1;
    step();

    // 1: single request
    t_single("t1");

    // 2: two simultaneous requests, back-to-back tenures
    bus.push = 2'b11;
    q.push_back('{cyc + 2, 2'b01});
    q.push_back('{cyc + 6, 2'b10});
    step();
    bus.push = '0;
    check_val("t2_req_c1",   32'(bus.req),   32'h3);
    check_val("t2_grant_c1", 32'(bus.grant), 32'h1);
    step();
    check_val("t2_busy_c2",  32'(bus.busy),  32'h2);
    check_val("t2_req_c2",   32'(bus.req),   32'h0);
    check_val("t2_own_c2",   32'(bus.owner), 32'h1);
    step(3);
    check_val("t2_req_c5",   32'(bus.req),    32'h2);
    check_val("t2_grant_c5", 32'(bus.grant),  32'h2);
    check_val("t2_act_c5",   32'(bus.active), 32'h0);
    step();
    check_val("t2_own_c6",   32'(bus.owner),  32'h2);
    check_val("t2_busy_c6",  32'(bus.busy),   32'h0);
    check_val("t2_act_c6",   32'(bus.active), 32'h1);
    step(3);
    check_val("t2_act_c9",   32'(bus.active), 32'h0);

    // 3: push collides with own grant
    bus.push = 2'b01;
    q.push_back('{cyc + 2, 2'b01});
    step();
    bus.push = 2'b01;
    q.push_back('{cyc + 5, 2'b01});
    check_val("t3_grant_c1", 32'(bus.grant), 32'h1);
    step();
    bus.push = '0;
    check_val("t3_busy_c2",  32'(bus.busy),   32'h1);
    check_val("t3_req_c2",   32'(bus.req),    32'h0);
    check_val("t3_act_c2",   32'(bus.active), 32'h1);
    step(3);
    check_val("t3_busy_c5",  32'(bus.busy),   32'h1);
    check_val("t3_req_c5",   32'(bus.req),    32'h1);
    check_val("t3_act_c5",   32'(bus.active), 32'h0);
    step();
    check_val("t3_own_c6",   32'(bus.owner),  32'h1);
    check_val("t3_busy_c6",  32'(bus.busy),   32'h0);
    step(3);
    check_val("t3_act_c9",   32'(bus.active), 32'h0);

    // 4: non-one-hot grant in IDLE, then err_clr
    force_en  = 1'b1;
    force_val = 2'b00;
    bus.push  = 2'b11;
    step();
    bus.push  = '0;
    check_val("t4_req_c1", 32'(bus.req), 32'h3);
    force_val = 2'b11;
    step();
    force_val = 2'b00;
    check_val("t4_err_c2",  32'(bus.err),    32'h1);
    check_val("t4_busy_c2", 32'(bus.busy),   32'h3);
    check_val("t4_act_c2",  32'(bus.active), 32'h0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check_val("t4_err_c3",  32'(bus.err), 32'h0);
    force_en = 1'b0;
    q.push_back('{cyc + 1, 2'b01});
    q.push_back('{cyc + 5, 2'b10});
    step(8);
    check_val("t4_act_end",  32'(bus.active), 32'h0);
    check_val("t4_busy_end", 32'(bus.busy),   32'h0);

    // 5: grant during TENURE with err_clr: set wins, tenure unaffected
    bus.push = 2'b01;
    q.push_back('{cyc + 2, 2'b01});
    step();
    bus.push = '0;
    step();
    check_val("t5_act_c2", 32'(bus.active), 32'h1);
    force_en    = 1'b1;
    force_val   = 2'b01;
    bus.err_clr = 1'b1;
    step();
    force_val   = 2'b00;
    bus.err_clr = 1'b0;
    check_val("t5_err_c3", 32'(bus.err),    32'h1);
    check_val("t5_own_c3", 32'(bus.owner),  32'h1);
    check_val("t5_act_c3", 32'(bus.active), 32'h1);
    step();
    check_val("t5_act_c4", 32'(bus.active), 32'h1);
    step();
    check_val("t5_act_c5", 32'(bus.active), 32'h0);
    check_val("t5_own_c5", 32'(bus.owner),  32'h0);
    force_en    = 1'b0;
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check_val("t5_err_c6", 32'(bus.err), 32'h0);

    // 6: asynchronous reset mid-tenure, then a fresh sequence
    bus.push = 2'b01;
    q.push_back('{cyc + 2, 2'b01});
    step();
    bus.push = '0;
    step(2);
    check_val("t6_act_c3", 32'(bus.active), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    step(2);
    #2 rst_n = 1'b1;
    step(2);
    check_val("t6_ack_after", 32'(bus.ack), 32'h0);
    t_single("t6");

    step(2);
    check_val("sb_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
